// File: rtl/sd_drive_arb_pkg.sv
// trs80 SD drive arbiter shared package.
// FSM states, parameter defaults and slot-wrap helper.
package trs80_sd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER,
    ST_DONE
  } arb_state_e;

  localparam int DEF_NDRV    = 5;
  localparam int DEF_LBAW    = 32;
  localparam int DEF_TIMEOUT = 1 << 20;

  function automatic int next_slot(
    input int s,
    input int n
  );
    return (s + 1 >= n) ? 0 : s + 1;
  endfunction

endpackage

// File: rtl/sd_drive_arb_if.sv
// hps_io block/buffer bundle between the arbiter and hps_io.
// master = arbiter side, slave = hps_io side.
interface sd_drive_arb_if
  import trs80_sd_pkg::*;
#(
  parameter int NDRV = DEF_NDRV,
  parameter int LBAW = DEF_LBAW
);

  logic [NDRV-1:0]           sd_rd;
  logic [NDRV-1:0]           sd_wr;
  logic [NDRV-1:0]           sd_ack;
  logic [NDRV-1:0][LBAW-1:0] sd_lba;
  logic                      sd_buff_wr;
  logic [NDRV-1:0][7:0]      sd_buff_din;

  modport master (
    output sd_rd,
    output sd_wr,
    output sd_lba,
    output sd_buff_din,
    input  sd_ack,
    input  sd_buff_wr
  );

  modport slave (
    input  sd_rd,
    input  sd_wr,
    input  sd_lba,
    input  sd_buff_din,
    output sd_ack,
    output sd_buff_wr
  );

endinterface

// File: rtl/sd_drive_arb_rr_pick.sv
// Masked round-robin priority encoder.
// Lowest request at or above ptr wins, else lowest overall.
module rr_pick
  import trs80_sd_pkg::*;
#(
  parameter  int NDRV = DEF_NDRV,
  localparam int AW   = (NDRV > 1) ? $clog2(NDRV) : 1
) (
  input  logic [NDRV-1:0] req,
  input  logic [AW-1:0]   ptr,
  output logic            valid,
  output logic [AW-1:0]   idx
);

  logic          hi_v;
  logic          lo_v;
  logic [AW-1:0] hi_idx;
  logic [AW-1:0] lo_idx;

  // scan downwards so the lowest hit in each half is kept
  always_comb begin
    hi_v   = 1'b0;
    lo_v   = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = NDRV - 1; i >= 0; i--) begin
      if (req[i] && (i >= int'(ptr))) begin
        hi_v   = 1'b1;
        hi_idx = AW'(i);
      end
      if (req[i]) begin
        lo_v   = 1'b1;
        lo_idx = AW'(i);
      end
    end
    valid = hi_v | lo_v;
    idx   = hi_v ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/sd_drive_arb.sv
// Arbiter between virtual drive slots and one hps_io block port.
// One transfer at a time; slot 0 (snapshots) is never granted.
module sd_drive_arb
  import trs80_sd_pkg::*;
#(
  parameter  int              NDRV    = DEF_NDRV,
  parameter  logic [NDRV-1:0] DRV_EN  = 5'b11110,
  parameter  int              LBAW    = DEF_LBAW,
  parameter  int              TIMEOUT = DEF_TIMEOUT,
  localparam int              AW      = (NDRV > 1) ? $clog2(NDRV) : 1,
  localparam int              TW      = $clog2(TIMEOUT + 1)
) (
  input  logic                      clk_sys,
  input  logic                      reset_n,
  input  logic [NDRV-1:0]           drv_rd,
  input  logic [NDRV-1:0]           drv_wr,
  input  logic [NDRV-1:0][LBAW-1:0] drv_lba,
  output logic [NDRV-1:0]           drv_done,
  output logic [NDRV-1:0]           drv_err,
  output logic [NDRV-1:0]           drv_buff_wr,
  input  logic [NDRV-1:0][7:0]      drv_buff_din,
  input  logic [NDRV-1:0]           img_mounted,
  input  logic [63:0]               img_size,
  sd_drive_arb_if.master            sd,
  output logic                      busy,
  output logic [AW-1:0]             active
);

  arb_state_e      state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [AW-1:0]   act_q, act_d;
  logic            wr_q, wr_d;
  logic [LBAW-1:0] lba_q, lba_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [NDRV-1:0] err_q, err_d;
  logic [NDRV-1:0] mnt_q;
  logic [NDRV-1:0] ack_q;

  logic            pick_v;
  logic [AW-1:0]   pick_idx;
  logic [NDRV-1:0] req_eff;
  logic            ack_rise;
  logic            ack_fall;
  logic            fail;

  // a slot whose err pulse is showing is still holding its level
  assign req_eff  = (drv_rd | drv_wr) & ~err_q;
  assign ack_rise = sd.sd_ack[act_q] & ~ack_q[act_q];
  assign ack_fall = ~sd.sd_ack[act_q] & ack_q[act_q];

  rr_pick #(.NDRV(NDRV)) u_pick (
    .req   (req_eff),
    .ptr   (ptr_q),
    .valid (pick_v),
    .idx   (pick_idx)
  );

  // arbiter state, latched grant and registered error pulses
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= AW'(1);
      act_q   <= '0;
      wr_q    <= 1'b0;
      lba_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      act_q   <= act_d;
      wr_q    <= wr_d;
      lba_q   <= lba_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // mount status per slot and ack history for edge detection
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mnt_q <= '0;
      ack_q <= '0;
    end else begin
      ack_q <= sd.sd_ack;
      for (int i = 0; i < NDRV; i++) begin
        if (img_mounted[i]) begin
          mnt_q[i] <= |img_size;
        end
      end
    end
  end

  // next state: grant, ack handshake, timeout and remount abort
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    act_d   = act_q;
    wr_d    = wr_q;
    lba_d   = lba_q;
    cnt_d   = cnt_q;
    err_d   = '0;
    fail    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_v) begin
          if (DRV_EN[pick_idx] && mnt_q[pick_idx]) begin
            state_d = ST_REQ;
            act_d   = pick_idx;
            wr_d    = drv_wr[pick_idx];
            lba_d   = drv_lba[pick_idx];
            cnt_d   = '0;
          end else begin
            err_d[pick_idx] = 1'b1;
            ptr_d = AW'(next_slot(int'(pick_idx), NDRV));
          end
        end
      end
      ST_REQ: begin
        if (img_mounted[act_q]) begin
          fail = 1'b1;
        end else if (ack_rise) begin
          state_d = ST_XFER;
        end else if (cnt_q == TW'(TIMEOUT - 1)) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_XFER: begin
        if (img_mounted[act_q]) begin
          fail = 1'b1;
        end else if (ack_fall) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ptr_d   = AW'(next_slot(int'(act_q), NDRV));
      end
      default: state_d = ST_IDLE;
    endcase
    if (fail) begin
      err_d[act_q] = 1'b1;
      state_d      = ST_IDLE;
      ptr_d        = AW'(next_slot(int'(act_q), NDRV));
    end
  end

  // outputs decoded from the registered state
  always_comb begin
    sd.sd_rd    = '0;
    sd.sd_wr    = '0;
    drv_buff_wr = '0;
    drv_done    = '0;
    unique case (state_q)
      ST_REQ: begin
        sd.sd_rd[act_q] = ~wr_q;
        sd.sd_wr[act_q] = wr_q;
      end
      ST_XFER: drv_buff_wr[act_q] = sd.sd_buff_wr;
      ST_DONE: drv_done[act_q] = 1'b1;
      default: ;
    endcase
    for (int i = 0; i < NDRV; i++) begin
      sd.sd_lba[i]      = lba_q;
      sd.sd_buff_din[i] = drv_buff_din[act_q];
    end
  end

  assign drv_err = err_q;
  assign busy    = (state_q != ST_IDLE);
  assign active  = act_q;

endmodule

// File: tb/tb_sd_drive_arb.sv
// Bench for sd_drive_arb: vector table, corner sequences
// and random traffic against a rotating-priority model.
module tb_sd_drive_arb;
  import trs80_sd_pkg::*;

  localparam int N  = 5;
  localparam int LW = 32;
  localparam int TO = 16;
  localparam logic [N-1:0] EN = 5'b11110;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  logic [N-1:0]         drv_rd, drv_wr;
  logic [N-1:0][LW-1:0] drv_lba;
  logic [N-1:0]         drv_done, drv_err, drv_buff_wr;
  logic [N-1:0][7:0]    drv_buff_din;
  logic [N-1:0]         img_mounted;
  logic [63:0]          img_size;
  logic                 busy;
  logic [2:0]           active;

  int tests = 0;
  int fails = 0;

  sd_drive_arb_if #(.NDRV(N), .LBAW(LW)) sd ();

  sd_drive_arb #(
    .NDRV(N), .DRV_EN(EN), .LBAW(LW), .TIMEOUT(TO)
  ) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .drv_rd       (drv_rd),
    .drv_wr       (drv_wr),
    .drv_lba      (drv_lba),
    .drv_done     (drv_done),
    .drv_err      (drv_err),
    .drv_buff_wr  (drv_buff_wr),
    .drv_buff_din (drv_buff_din),
    .img_mounted  (img_mounted),
    .img_size     (img_size),
    .sd           (sd),
    .busy         (busy),
    .active       (active)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int          slot;
    bit          rd;
    bit          wr;
    logic [31:0] lba;
    int          alen;
    int          kind;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic int lowbit(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic mount(input logic [N-1:0] m,
                       input logic [63:0] sz);
    img_mounted = m;
    img_size    = sz;
    step();
    img_mounted = '0;
  endtask

  // kind: 0 nothing seen, 1 grant (sd_rd/sd_wr), 2 error pulse
  task automatic wait_evt(output int kind, output int slot);
    kind = 0;
    slot = -1;
    for (int n = 0; n < 12 && kind == 0; n++) begin
      step();
      if (drv_err != 0) begin
        kind = 2;
        slot = lowbit(drv_err);
      end else if ((sd.sd_rd | sd.sd_wr) != 0) begin
        kind = 1;
        slot = lowbit(sd.sd_rd | sd.sd_wr);
      end
    end
  endtask

  // called in the first REQ cycle; returns in the done cycle
  task automatic serve(input int s, input int alen);
    int o;
    o = (s + 1) % N;
    sd.sd_ack[o] = 1'b1;
    step();
    sd.sd_ack[o] = 1'b0;
    check("foreign_ack_ignored",
          64'(sd.sd_rd[s] | sd.sd_wr[s]), 64'd1);
    sd.sd_ack[s] = 1'b1;
    step();
    check("xfer_req_low", 64'(sd.sd_rd | sd.sd_wr), 0);
    drv_buff_din[s] = 8'($urandom);
    sd.sd_buff_wr = 1'b1;
    #1;
    check("buff_wr_gate", 64'(drv_buff_wr), 64'(1) << s);
    check("buff_din", 64'(sd.sd_buff_din[N-1]),
          64'(drv_buff_din[s]));
    sd.sd_buff_wr = 1'b0;
    #1;
    check("buff_wr_idle", 64'(drv_buff_wr), 0);
    for (int i = 1; i < alen; i++) step();
    sd.sd_ack[s] = 1'b0;
    step();
    check("done_after_fall", 64'(drv_done), 64'(1) << s);
  endtask

  task automatic run_vec(input vec_t v, input int k);
    int kind, slot;
    drv_rd[v.slot]  = v.rd;
    drv_wr[v.slot]  = v.wr;
    drv_lba[v.slot] = v.lba;
    wait_evt(kind, slot);
    check($sformatf("v%0d_kind", k), 64'(kind), 64'(v.kind));
    check($sformatf("v%0d_slot", k), 64'(slot), 64'(v.slot));
    if (kind == 1 && slot == v.slot) begin
      check($sformatf("v%0d_wr", k), 64'(sd.sd_wr[slot]), 64'(v.wr));
      check($sformatf("v%0d_rd", k), 64'(sd.sd_rd[slot]), 64'(!v.wr));
      check($sformatf("v%0d_lba0", k), 64'(sd.sd_lba[0]), 64'(v.lba));
      check($sformatf("v%0d_lba4", k), 64'(sd.sd_lba[N-1]), 64'(v.lba));
      check($sformatf("v%0d_busy", k), 64'(busy), 1);
      check($sformatf("v%0d_active", k), 64'(active), 64'(v.slot));
      serve(slot, v.alen);
    end else if (kind == 2) begin
      check($sformatf("v%0d_err_sd", k), 64'(sd.sd_rd | sd.sd_wr), 0);
      check($sformatf("v%0d_err_busy", k), 64'(busy), 0);
    end
    drv_rd[v.slot] = 1'b0;
    drv_wr[v.slot] = 1'b0;
    step();
    check($sformatf("v%0d_pulse1", k), 64'(drv_done | drv_err), 0);
    check($sformatf("v%0d_sd_idle", k), 64'(sd.sd_rd | sd.sd_wr), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, slot, n, p, exp_s, exp_k;
    logic got_err;
    logic [N-1:0] seen, m, pend, w;
    logic [N-1:0][LW-1:0] lbas;
    int exp_rr[4];

    drv_rd = '0; drv_wr = '0; drv_lba = '0;
    drv_buff_din = '0; img_mounted = '0; img_size = '0;
    sd.sd_ack = '0; sd.sd_buff_wr = 1'b0;

    tbl[0] = '{2, 1'b1, 1'b0, 32'h12, 256, 1};
    tbl[1] = '{0, 1'b1, 1'b0, 32'h1, 1, 2};
    tbl[2] = '{4, 1'b1, 1'b0, 32'h2, 1, 2};
    tbl[3] = '{3, 1'b0, 1'b1, 32'hABCD, 3, 1};
    tbl[4] = '{1, 1'b1, 1'b1, 32'h777, 1, 1};
    tbl[5] = '{1, 1'b1, 1'b0, 32'hFFFF_FFFF, 2, 1};

    step();
    step();
    check("rst_busy", 64'(busy), 0);
    check("rst_active", 64'(active), 0);
    check("rst_sd", 64'(sd.sd_rd | sd.sd_wr), 0);
    check("rst_lba", 64'(sd.sd_lba[0]), 0);
    check("rst_pulses", 64'(drv_done | drv_err | drv_buff_wr), 0);
    reset_n = 1'b1;
    step();

    mount(5'b01111, 64'd4096);
    mount(5'b10000, 64'd0);
    foreach (tbl[i]) run_vec(tbl[i], i);

    // round robin from the reset pointer
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    mount(5'b01110, 64'd512);
    exp_rr = '{1, 3, 1, 3};
    drv_rd[1] = 1'b1;
    drv_rd[3] = 1'b1;
    foreach (exp_rr[i]) begin
      wait_evt(kind, slot);
      check($sformatf("rr%0d_slot", i), 64'(slot), 64'(exp_rr[i]));
      if (kind == 1 && slot >= 0) serve(slot, 2);
    end
    drv_rd = '0;
    step();
    step();

    // no ack: timeout error after TO request cycles
    drv_rd[2] = 1'b1;
    n = 0;
    got_err = 1'b0;
    for (int i = 0; i < 40 && !got_err; i++) begin
      step();
      if (drv_err != 0) got_err = 1'b1;
      else if (sd.sd_rd[2]) n++;
    end
    check("to_fired", 64'(got_err), 1);
    check("to_len", 64'(n), 64'(TO));
    check("to_err_slot", 64'(drv_err), 64'(5'b00100));
    check("to_rd_low", 64'(sd.sd_rd), 0);
    drv_rd[2] = 1'b0;
    step();

    // unmount of the active slot during REQ aborts
    drv_rd[3] = 1'b1;
    wait_evt(kind, slot);
    check("ab_grant", 64'(slot), 3);
    mount(5'b01000, 64'd0);
    check("ab_err", 64'(drv_err), 64'(5'b01000));
    check("ab_sd", 64'(sd.sd_rd | sd.sd_wr), 0);
    check("ab_busy", 64'(busy), 0);
    drv_rd[3] = 1'b0;
    step();
    drv_rd[3] = 1'b1;
    wait_evt(kind, slot);
    check("ab_unmounted_err", 64'(kind), 2);
    drv_rd[3] = 1'b0;
    step();
    mount(5'b01000, 64'd1);

    // reset during XFER on slot 3
    drv_rd[3] = 1'b1;
    wait_evt(kind, slot);
    check("rx_grant", 64'(slot), 3);
    sd.sd_ack[3] = 1'b1;
    step();
    sd.sd_buff_wr = 1'b1;
    #1;
    check("rx_buff_wr", 64'(drv_buff_wr), 64'(5'b01000));
    reset_n = 1'b0;
    #1;
    check("rx_busy", 64'(busy), 0);
    check("rx_buff_wr0", 64'(drv_buff_wr), 0);
    check("rx_sd", 64'(sd.sd_rd | sd.sd_wr), 0);
    check("rx_pulses", 64'(drv_done | drv_err), 0);
    check("rx_lba", 64'(sd.sd_lba[3]), 0);
    check("rx_active", 64'(active), 0);
    drv_rd[3] = 1'b0;
    sd.sd_ack[3] = 1'b0;
    sd.sd_buff_wr = 1'b0;
    step();
    reset_n = 1'b1;
    seen = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      seen |= drv_done | drv_err;
    end
    check("rx_no_done", 64'(seen), 0);

    // random traffic; model searches p, p+1, ... mod N
    p = 1;
    for (int r = 0; r < 40; r++) begin
      m = N'($urandom);
      pend = N'($urandom);
      if (pend == 0) pend[$urandom_range(0, N - 1)] = 1'b1;
      w = N'($urandom);
      mount(m, 64'($urandom_range(1, 100000)));
      mount(~m, 64'd0);
      for (int i = 0; i < N; i++) begin
        lbas[i] = $urandom;
        drv_lba[i] = lbas[i];
        drv_wr[i] = pend[i] & w[i];
        drv_rd[i] = pend[i] & (~w[i] | 1'($urandom));
      end
      for (int it = 0; it < N && pend != 0; it++) begin
        exp_s = -1;
        for (int k = 0; k < N; k++) begin
          if (exp_s < 0 && pend[(p + k) % N]) exp_s = (p + k) % N;
        end
        exp_k = (EN[exp_s] && m[exp_s]) ? 1 : 2;
        wait_evt(kind, slot);
        check("rnd_kind", 64'(kind), 64'(exp_k));
        check("rnd_slot", 64'(slot), 64'(exp_s));
        if (kind == 1 && slot >= 0) begin
          check("rnd_wr", 64'(sd.sd_wr[slot]), 64'(w[slot]));
          check("rnd_lba", 64'(sd.sd_lba[1]), 64'(lbas[slot]));
          serve(slot, $urandom_range(1, 4));
        end
        if (slot >= 0) begin
          drv_rd[slot] = 1'b0;
          drv_wr[slot] = 1'b0;
        end
        drv_rd[exp_s] = 1'b0;
        drv_wr[exp_s] = 1'b0;
        pend[exp_s] = 1'b0;
        p = (exp_s + 1) % N;
      end
      drv_rd = '0;
      drv_wr = '0;
    end
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sd_drive_arb.md
SD_DRIVE_ARB -- requirements
Module: sd_drive_arb

Interface
REQ-001 Parameter NDRV, default 5: number of virtual drive slots served by hps_io.
REQ-002 Parameter DRV_EN, default 5'b11110: slot enable mask; slot 0 is reserved for snapshot files and is never granted.
REQ-003 Parameter LBAW, default 32: LBA width.
REQ-004 Parameter TIMEOUT, default 2^20: clk_sys cycles allowed between request and sd_ack rise.
REQ-005 clk_sys  in  1  system clock, 42 MHz.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 drv_rd / drv_wr  in  NDRV each  per-drive sector read/write request; a level held until drv_done or drv_err.
REQ-008 drv_lba  in  NDRV x LBAW  per-drive sector address, sampled at grant.
REQ-009 drv_done / drv_err  out  NDRV each  one-cycle completion and failure pulses.
REQ-010 drv_buff_wr  out  NDRV  sd_buff_wr gated to the active drive.
REQ-011 drv_buff_din  in  NDRV x 8  per-drive write data.
REQ-012 img_mounted  in  NDRV; img_size  in  64  mount pulses and image size.
REQ-013 sd_rd / sd_wr  out  NDRV; sd_lba  out  NDRV x LBAW; sd_ack  in  NDRV  hps_io block interface.
REQ-014 sd_buff_wr  in  1; sd_buff_din  out  NDRV x 8  hps_io buffer interface.
REQ-015 busy  out  1; active  out  clog2(NDRV)  status.

Function
REQ-016 FSM states: IDLE, REQ, XFER, DONE.
REQ-017 IDLE: round-robin pick, starting at slot after last served, of lowest enabled slot with drv_rd|drv_wr; latch slot, direction, drv_lba; go to REQ next cycle.
REQ-018 Request to a slot that is disabled or not mounted: drv_err pulse next cycle, no sd_rd/sd_wr, FSM stays IDLE, pointer advances.
REQ-019 drv_rd and drv_wr both high on the granted slot: write served first.
REQ-020 REQ: assert sd_rd[active] or sd_wr[active] and drive latched LBA on all sd_lba entries; leave on sd_ack[active] rise -> XFER.
REQ-021 REQ timeout counter reaching TIMEOUT: drop request, pulse drv_err[active], return to IDLE.
REQ-022 XFER: deassert sd_rd/sd_wr; drv_buff_wr[active]=sd_buff_wr combinationally, others 0; sd_buff_din all entries = drv_buff_din[active]; on sd_ack[active] fall -> DONE.
REQ-023 DONE: pulse drv_done[active] one cycle; IDLE next cycle; pointer = active+1, wrapping at NDRV to 0.
REQ-024 Minimum grant-to-done latency 3 cycles plus hps_io ack duration.
REQ-025 img_mounted[i] pulse: mounted[i] <= (img_size != 0); a pulse on the active slot during REQ/XFER aborts to IDLE with drv_err[active].
REQ-026 sd_ack on a non-active slot is ignored.
REQ-027 busy = state != IDLE.

Reset
REQ-028 reset_n low: state IDLE, pointer 1, mounted 0, timeout counter 0, all sd_rd/sd_wr/drv_done/drv_err/drv_buff_wr 0, sd_lba 0, active 0, effective immediately.
REQ-029 Reset mid-transfer: request dropped, no done/err pulse.

Structure
REQ-030 Package trs80_sd_pkg: FSM state enum, default NDRV, TIMEOUT, LBAW.
REQ-031 Sub-module rr_pick (masked round-robin priority encoder, NDRV-parameterised).

Verification
REQ-032 Slot 2 mounted, drv_rd[2], lba 0x12 -> sd_rd[2]=1, sd_lba=0x12; ack 256 cycles -> drv_done[2] one pulse after ack fall.
REQ-033 Slots 1,3 requesting together, pointer 1 -> slot 1 served then slot 3; then slot 1 again served before slot 3 only after pointer wraps.
REQ-034 drv_rd[0] or unmounted slot 4 -> drv_err pulse next cycle, sd_rd stays 0.
REQ-035 No ack for TIMEOUT=16 -> drv_err at cycle 16, sd_rd deasserted.
REQ-036 XFER on slot 3, sd_buff_wr pulses -> only drv_buff_wr[3] toggles; reset_n low mid-XFER -> all outputs 0, no done.
